pcie_commit_rx_merge: RTL
=========================

# pcie_commit_rx_merge

Packet-atomic arbiter that merges the locally generated write-commit stream into the host-to-AFU RX stream of one PF/VF MUX tree port. Commits are single-beat completions without data, one per AFU write or interrupt request. They are latency-sensitive, so they win arbitration at packet boundaries. A burst limit guarantees that multi-beat RX traffic (host completions and requests) still makes progress. Sits between the FIM RX path, the commit skid buffer and the AFU-facing RX port.

## Interface
Parameters:
- TDATA_WIDTH, ofs_pcie_ss_cfg_pkg::TDATA_WIDTH, data width of all streams
- TUSER_WIDTH, ofs_pcie_ss_cfg_pkg::TUSER_WIDTH, tuser_vendor width of all streams
- MAX_COMMIT_BURST, 4, consecutive commit grants allowed while RX is waiting; legal range 1..15

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- rx_in  pcie_ss_axis_if.sink  —  host RX packets, multi-beat, framed by tlast
- commit_in  pcie_ss_axis_if.sink  —  local commits; every beat is a complete packet
- rx_out  pcie_ss_axis_if.source  —  merged stream toward the AFU
- commit_cnt  out  32  saturating count of commits forwarded; reads 0 when the counter feature is compiled out

## Operation
- FSM states:
  - IDLE: at a packet boundary.
  - RX_LOCK: inside an RX packet.
- Arbitration runs only in IDLE, on cycles where the output stage can accept a beat (`acc = !out_valid || rx_out.tready`).
- Grant rules in IDLE:
  - If commit_in.tvalid and (burst_cnt < MAX_COMMIT_BURST or !rx_in.tvalid): grant commit.
  - Otherwise, if rx_in.tvalid: grant RX.
  - Otherwise: no grant.
- Commit grant:
  - Sets commit_in.tready=1 for that cycle.
  - Increments burst_cnt, saturating at MAX_COMMIT_BURST.
  - FSM stays in IDLE.
  - The beat is forwarded with tlast forced to 1.
- RX grant:
  - Sets rx_in.tready=acc.
  - Clears burst_cnt to 0.
  - If the beat has tlast=0, FSM goes to RX_LOCK; a single-beat packet keeps it in IDLE.
- RX_LOCK:
  - rx_in.tready=acc and commit_in.tready=0.
  - Leaves for IDLE on the transfer of the rx_in beat with tlast=1.
  - An rx_in.tvalid bubble mid-packet keeps the lock; commits wait.
- burst_cnt also clears in IDLE on any cycle with commit_in.tvalid=0.
- Output stage:
  - Single registered beat holding tdata, tkeep, tlast and tuser_vendor, loaded whenever a granted beat transfers.
  - out_valid clears when rx_out.tready=1 and no new beat is loaded.
  - All fields pass through unmodified, except commit tlast as noted above.
- Widths: burst_cnt is 4 bits; commit_cnt is 32 bits and saturates at 0xFFFF_FFFF.

## Timing
- Latency: 1 cycle from input transfer to rx_out.tvalid.
- Throughput: one beat per cycle while rx_out.tready=1.
- Input readies are combinational on rx_out.tready, out_valid, FSM state and the input valids.
- No tvalid-to-tready dependency exists within a single input.
- rx_out.tvalid never depends combinationally on rx_out.tready.
- Once asserted, rx_out.tvalid holds with stable data until accepted.
- Reset values:
  - rx_out.tvalid=0, rx_out.tlast=0, data fields don't-care.
  - rx_in.tready=0 and commit_in.tready=0 while rst_n=0.
  - FSM=IDLE, burst_cnt=0, commit_cnt=0.
- Reset asserted mid-packet: the FSM returns to IDLE, the buffered beat is dropped and no partial-packet recovery is attempted. Upstream resets together with this block.
- Simultaneous valid on both inputs in IDLE with burst_cnt=MAX_COMMIT_BURST: RX wins and burst_cnt becomes 0. The commit is granted at the next boundary.

## Configuration
- Macro: PCIE_COMMIT_MERGE_CNT_EN.
- Defined: commit_cnt increments by 1 on every commit_in transfer and saturates.
- Undefined: the counter register is not built and commit_cnt is tied to 32'h0.
- Arbitration and datapath are identical in both builds.

## Test plan
- Commit-only traffic, 10 back-to-back commits, rx_out.tready=1: 10 rx_out beats in consecutive cycles, each with tlast=1 and tdata equal to its input, first beat 1 cycle after the first commit transfer; commit_cnt=10 (macro on).
- 4-beat RX packet with commits valid from beat 2: all 4 RX beats emitted contiguously, then the commits; no commit interleaves inside the packet.
- MAX_COMMIT_BURST=4, both inputs continuously valid with single-beat RX packets: output pattern repeats 4 commits, 1 RX.
- rx_out.tready toggled randomly at 50% with mixed traffic: no beat lost or duplicated, tvalid/tdata stable while stalled, per-source order preserved.
- Reset asserted during beat 2 of a 3-beat RX packet: rx_out.tvalid=0 immediately; after release, a pending commit is granted first (FSM in IDLE).
- Build with the macro undefined and 5 commits sent: commit_cnt=0 while the output stream matches the macro-on build.

Source files
------------

// File: rtl/pcie_commit_rx_merge.sv
// ---------------------------------------------------------------------------
// pcie_commit_rx_merge
//
// Packet-atomic arbiter that merges the locally generated write-commit
// stream into the host-to-AFU RX stream of one PF/VF MUX tree port.
// Commits are single-beat completions and win arbitration at packet
// boundaries. A burst limit lets waiting multi-beat RX traffic make progress.
// RX packets are never interleaved with commits.
//
// Optional feature macro: PCIE_COMMIT_MERGE_CNT_EN
//   defined   -> commit_cnt_o is a saturating count of forwarded commits
//   undefined -> no counter register is built, commit_cnt_o reads 32'h0
//
// Parameters:
//   TDATA_WIDTH       data width of all streams
//   TUSER_WIDTH       tuser_vendor width of all streams
//   MAX_COMMIT_BURST  consecutive commit grants allowed while RX waits (1..15)
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   rx_in_*                host RX packets (sink), multi-beat, framed by tlast
//   commit_in_*            local commits (sink), every beat is a packet
//   rx_out_*               merged stream toward the AFU (source)
//   commit_cnt_o           saturating commit count (0 when compiled out)
// ---------------------------------------------------------------------------
module pcie_commit_rx_merge #(
    parameter int TDATA_WIDTH      = 512,
    parameter int TUSER_WIDTH      = 10,
    parameter int MAX_COMMIT_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     rx_in_tvalid_i,
    output logic                     rx_in_tready_o,
    input  logic [TDATA_WIDTH-1:0]   rx_in_tdata_i,
    input  logic [TDATA_WIDTH/8-1:0] rx_in_tkeep_i,
    input  logic                     rx_in_tlast_i,
    input  logic [TUSER_WIDTH-1:0]   rx_in_tuser_vendor_i,

    input  logic                     commit_in_tvalid_i,
    output logic                     commit_in_tready_o,
    input  logic [TDATA_WIDTH-1:0]   commit_in_tdata_i,
    input  logic [TDATA_WIDTH/8-1:0] commit_in_tkeep_i,
    input  logic                     commit_in_tlast_i,
    input  logic [TUSER_WIDTH-1:0]   commit_in_tuser_vendor_i,

    output logic                     rx_out_tvalid_o,
    input  logic                     rx_out_tready_i,
    output logic [TDATA_WIDTH-1:0]   rx_out_tdata_o,
    output logic [TDATA_WIDTH/8-1:0] rx_out_tkeep_o,
    output logic                     rx_out_tlast_o,
    output logic [TUSER_WIDTH-1:0]   rx_out_tuser_vendor_o,

    output logic [31:0]              commit_cnt_o
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_COMMIT_BURST);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_RX_LOCK = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [3:0]               burst_cnt_q, burst_cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_tlast_q, out_tlast_d;
    logic [TDATA_WIDTH-1:0]   out_tdata_q, out_tdata_d;
    logic [TDATA_WIDTH/8-1:0] out_tkeep_q, out_tkeep_d;
    logic [TUSER_WIDTH-1:0]   out_tuser_q, out_tuser_d;

    logic acc;
    logic burst_ok;
    logic rx_xfer;
    logic commit_xfer;
    logic load;

    // -----------------------------------------------------------------------
    // Arbitration, input readies and next-state
    // -----------------------------------------------------------------------
    always_comb begin
        acc                = !out_valid_q || rx_out_tready_i;
        burst_ok           = (burst_cnt_q < BURST_MAX);
        rx_in_tready_o     = 1'b0;
        commit_in_tready_o = 1'b0;
        state_d            = state_q;
        burst_cnt_d        = burst_cnt_q;

        // Readies are built without looking at the same input's tvalid:
        // commit ready only looks at rx valid, rx ready only at commit valid.
        // The two can never both produce a transfer in the same cycle.
        if (rst_n) begin
            case (state_q)
                S_IDLE: begin
                    commit_in_tready_o = acc && (burst_ok || !rx_in_tvalid_i);
                    rx_in_tready_o     = acc && !(commit_in_tvalid_i && burst_ok);
                end
                S_RX_LOCK: begin
                    rx_in_tready_o = acc;
                end
                default: ;
            endcase
        end

        rx_xfer     = rx_in_tvalid_i && rx_in_tready_o;
        commit_xfer = commit_in_tvalid_i && commit_in_tready_o;
        load        = rx_xfer || commit_xfer;

        case (state_q)
            S_IDLE: begin
                if (commit_xfer) begin
                    if (burst_ok) begin
                        burst_cnt_d = burst_cnt_q + 4'd1;
                    end
                end else if (rx_xfer || !commit_in_tvalid_i) begin
                    burst_cnt_d = 4'd0;
                end
                if (rx_xfer && !rx_in_tlast_i) begin
                    state_d = S_RX_LOCK;
                end
            end
            S_RX_LOCK: begin
                if (rx_xfer && rx_in_tlast_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output stage next values
    // -----------------------------------------------------------------------
    always_comb begin
        out_valid_d = load || (out_valid_q && !rx_out_tready_i);
        out_tlast_d = out_tlast_q;
        out_tdata_d = out_tdata_q;
        out_tkeep_d = out_tkeep_q;
        out_tuser_d = out_tuser_q;
        if (commit_xfer) begin
            // A commit is always a whole packet, whatever its tlast says.
            out_tlast_d = 1'b1;
            out_tdata_d = commit_in_tdata_i;
            out_tkeep_d = commit_in_tkeep_i;
            out_tuser_d = commit_in_tuser_vendor_i;
        end else if (rx_xfer) begin
            out_tlast_d = rx_in_tlast_i;
            out_tdata_d = rx_in_tdata_i;
            out_tkeep_d = rx_in_tkeep_i;
            out_tuser_d = rx_in_tuser_vendor_i;
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            burst_cnt_q <= 4'd0;
            out_valid_q <= 1'b0;
            out_tlast_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            out_valid_q <= out_valid_d;
            out_tlast_q <= out_tlast_d;
        end
    end

    // Data fields are qualified by out_valid_q and need no reset.
    always_ff @(posedge clk) begin
        out_tdata_q <= out_tdata_d;
        out_tkeep_q <= out_tkeep_d;
        out_tuser_q <= out_tuser_d;
    end

    assign rx_out_tvalid_o       = out_valid_q;
    assign rx_out_tlast_o        = out_tlast_q;
    assign rx_out_tdata_o        = out_tdata_q;
    assign rx_out_tkeep_o        = out_tkeep_q;
    assign rx_out_tuser_vendor_o = out_tuser_q;

    // -----------------------------------------------------------------------
    // Optional commit counter
    // -----------------------------------------------------------------------
`ifdef PCIE_COMMIT_MERGE_CNT_EN
    logic [31:0] commit_cnt_q, commit_cnt_d;

    always_comb begin
        commit_cnt_d = commit_cnt_q;
        if (commit_xfer && (commit_cnt_q != 32'hFFFF_FFFF)) begin
            commit_cnt_d = commit_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_cnt_q <= 32'd0;
        end else begin
            commit_cnt_q <= commit_cnt_d;
        end
    end

    assign commit_cnt_o = commit_cnt_q;
`else
    assign commit_cnt_o = 32'h0;
`endif

endmodule
